// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: sample/product widths, demodulator states and
// the (I,Q) bit-pair constants also used by the transmit-side selector.
package qpsk_pkg;

  localparam int SAMPLE_W = 10;
  localparam int PROD_W   = 20;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } demod_state_e;

  // {Ichannel, Qchannel}
  localparam logic [1:0] SYM00 = 2'b00;
  localparam logic [1:0] SYM01 = 2'b01;
  localparam logic [1:0] SYM11 = 2'b11;
  localparam logic [1:0] SYM10 = 2'b10;

endpackage

// File: rtl/qpsk_demod_if.sv
// Sample-side and decision-side signals of the QPSK demodulator.
// Optional macro QPSK_DEMOD_SOFT_EN adds the soft_i/soft_q correlation sums.
interface qpsk_demod_if
`ifdef QPSK_DEMOD_SOFT_EN
  #(parameter int ACC_W = 24)
`endif
  ;
  import qpsk_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_in;
  logic signed [SAMPLE_W-1:0] ref_i;
  logic signed [SAMPLE_W-1:0] ref_q;
  logic                       sample_valid;
  logic                       sym_sync;
  logic                       Ichannel;
  logic                       Qchannel;
  logic                       sym_valid;
  logic                       locked;
`ifdef QPSK_DEMOD_SOFT_EN
  logic signed [ACC_W-1:0]    soft_i;
  logic signed [ACC_W-1:0]    soft_q;

  modport master (output sample_in, ref_i, ref_q, sample_valid, sym_sync,
                  input  Ichannel, Qchannel, sym_valid, locked, soft_i, soft_q);
  modport slave  (input  sample_in, ref_i, ref_q, sample_valid, sym_sync,
                  output Ichannel, Qchannel, sym_valid, locked, soft_i, soft_q);
`else
  modport master (output sample_in, ref_i, ref_q, sample_valid, sym_sync,
                  input  Ichannel, Qchannel, sym_valid, locked);
  modport slave  (input  sample_in, ref_i, ref_q, sample_valid, sym_sync,
                  output Ichannel, Qchannel, sym_valid, locked);
`endif

endinterface

// File: rtl/qpsk_correlator.sv
// One multiply-accumulate lane: sample * reference summed over a symbol.
// o_full is the running sum including the current product, so the top can
// decide on the last sample without an extra cycle.
module qpsk_correlator
  import qpsk_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] i_ref,
  input  logic                       i_clear,
  input  logic                       i_load,
  input  logic                       i_acc,
  output logic signed [ACC_W-1:0]    o_full
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = i_sample * i_ref;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign o_full     = r_acc + w_prod_ext;

  // Accumulator: load starts a new symbol with sample 0, clear empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_prod_ext;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_acc) begin
      r_acc <= o_full;
    end
  end

endmodule

// File: rtl/qpsk_demod.sv
// QPSK symbol detector: correlates the received stream against the I/Q
// reference carriers over SPS samples and decides one bit pair per symbol.
// Optional macro QPSK_DEMOD_SOFT_EN exports the full correlation sums.
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter int SPS   = 16,
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  qpsk_demod_if.slave bus
);

  localparam int                CNT_W    = $clog2(SPS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPS - 1);

  demod_state_e            r_state;
  demod_state_e            w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_load;
  logic                    w_clear;
  logic                    w_acc;
  logic                    w_decide;
  logic signed [ACC_W-1:0] w_full_i;
  logic signed [ACC_W-1:0] w_full_q;
  logic                    r_ich;
  logic                    r_qch;
  logic                    r_sym_valid;
  logic                    r_locked;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACQ;
    else        r_state <= w_state_nxt;
  end

  // Next state: any symbol strobe acquires; only reset returns to ACQ.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.sym_sync) w_state_nxt = TRACK;
  end

  // Control decode: a strobe always restarts the symbol, even on the last sample.
  always_comb begin
    w_load   = 1'b0;
    w_clear  = 1'b0;
    w_acc    = 1'b0;
    w_decide = 1'b0;
    if (bus.sym_sync) begin
      w_load  = bus.sample_valid;
      w_clear = !bus.sample_valid;
    end else if (r_state == TRACK && bus.sample_valid) begin
      if (r_cnt == CNT_LAST) begin
        w_decide = 1'b1;
        w_clear  = 1'b1;
      end else begin
        w_acc = 1'b1;
      end
    end
  end

  // Sample counter within the current symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_load)  r_cnt <= CNT_W'(1);
    else if (w_clear) r_cnt <= '0;
    else if (w_acc)   r_cnt <= r_cnt + 1'b1;
  end

  qpsk_correlator #(.ACC_W(ACC_W)) u_corr_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (bus.sample_in),
    .i_ref    (bus.ref_i),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_acc    (w_acc),
    .o_full   (w_full_i)
  );

  qpsk_correlator #(.ACC_W(ACC_W)) u_corr_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (bus.sample_in),
    .i_ref    (bus.ref_q),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_acc    (w_acc),
    .o_full   (w_full_q)
  );

  // Decision registers: sign of the full sum, zero decides 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ich       <= 1'b0;
      r_qch       <= 1'b0;
      r_sym_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_sym_valid <= w_decide;
      if (w_decide) begin
        r_ich <= !w_full_i[ACC_W-1];
        r_qch <= !w_full_q[ACC_W-1];
      end
      if (bus.sym_sync) r_locked <= 1'b1;
    end
  end

  assign bus.Ichannel  = r_ich;
  assign bus.Qchannel  = r_qch;
  assign bus.sym_valid = r_sym_valid;
  assign bus.locked    = r_locked;

`ifdef QPSK_DEMOD_SOFT_EN
  logic signed [ACC_W-1:0] r_soft_i;
  logic signed [ACC_W-1:0] r_soft_q;

  // Soft sums captured alongside the hard decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_soft_i <= '0;
      r_soft_q <= '0;
    end else if (w_decide) begin
      r_soft_i <= w_full_i;
      r_soft_q <= w_full_q;
    end
  end

  assign bus.soft_i = r_soft_i;
  assign bus.soft_q = r_soft_q;
`endif

endmodule

// File: doc/qpsk_demod.md
Name: qpsk_demod

Overview:
QPSK receive-side symbol detector, the counterpart of the QPSK output selector that maps Ichannel/Qchannel to one of four 10-bit carrier sample streams.
- Takes the received 10-bit signed sample stream plus locally generated I (cos) and Q (sin) reference carriers.
- Correlates over each symbol period and decides one (Ichannel, Qchannel) bit pair per symbol.
- Sits after the channel/ADC model and before bit deserialisation.

Parameters:
SPS, 16, samples per symbol (>=2)
ACC_W, 24, correlator accumulator width in bits; must be >= 20 + clog2(SPS)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
sample_in  input  10  signed received sample
ref_i  input  10  signed I reference carrier sample, time-aligned with sample_in
ref_q  input  10  signed Q reference carrier sample, time-aligned with sample_in
sample_valid  input  1  sample_in/ref_i/ref_q valid this cycle
sym_sync  input  1  symbol-boundary strobe; this cycle is sample 0 of a symbol
Ichannel  output  1  decided I bit
Qchannel  output  1  decided Q bit
sym_valid  output  1  one-cycle pulse: Ichannel/Qchannel updated this cycle
locked  output  1  high once the first sym_sync has been accepted

Behaviour:
- Reset (rst_n low, asynchronous): state=ACQ, sample counter=0, acc_i=acc_q=0, Ichannel=0, Qchannel=0, sym_valid=0, locked=0.
- Products: p_i = sample_in*ref_i, p_q = sample_in*ref_q, each 20-bit signed, sign-extended to ACC_W. No saturation needed; the ACC_W rule guarantees no overflow (worst case -512*-512*SPS).
- ACQ: all samples are ignored until sym_sync=1 with sample_valid=1.
  - On that edge: acc_i=p_i, acc_q=p_q, cnt=1, go to TRACK, locked=1.
  - sym_sync with sample_valid=0 in ACQ: go to TRACK, cnt=0, acc=0, locked=1.
- TRACK, sample_valid=1, cnt<SPS-1: acc += p, cnt++.
- TRACK, sample_valid=1, cnt==SPS-1 (last sample): on this edge
  - full_i = acc_i + p_i and full_q = acc_q + p_q
  - Ichannel = (full_i >= 0); Qchannel = (full_q >= 0); zero ties decide 1
  - sym_valid=1 for exactly this one cycle
  - acc_i=acc_q=0, cnt=0
  - Decision latency is 1 clock from the last sample.
- sample_valid=0: no state change; sym_valid=0; Ichannel/Qchannel hold their last value.
- sym_sync=1 in TRACK (resync) discards any partial symbol without a sym_valid pulse.
  - With sample_valid=1, that sample is sample 0: acc=p, cnt=1.
  - With sample_valid=0: acc=0, cnt=0.
- sym_sync on the same edge as a cnt==SPS-1 sample: sync wins; no decision, no sym_valid, and the sample is taken as sample 0.
- Ichannel/Qchannel change only on a sym_valid cycle.
- locked stays 1 until reset.
- Reset asserted mid-symbol: the partial symbol is lost and the block returns to ACQ.

Optional Feature:
QPSK_DEMOD_SOFT_EN
- Defined: adds outputs soft_i and soft_q (signed, ACC_W wide), holding full_i and full_q. They are registered on the sym_valid edge, held otherwise, and reset to 0. Used for BER/SNR measurement benches.
- Undefined: the ports and registers are absent and hard decisions are unchanged.

Decomposition:
- Package qpsk_pkg: SAMPLE_W=10, PROD_W=20, the demodulator state enum {ACQ, TRACK}, and bit-pair constants SYM00/SYM01/SYM11/SYM10 shared with the transmit selector.
- Sub-module qpsk_correlator: one MAC lane holding the acc register, clear/load/accumulate controls and full-sum output. Instantiated twice (I and Q); the counter and FSM stay in qpsk_demod.

Test Plan:
- Reset values: assert rst_n=0 mid-run -> all outputs 0 immediately (asynchronous) and locked=0.
- Lock and decide: sym_sync+valid, then 16 valid samples with sample_in=100, ref_i=100, ref_q=-50 -> after the 16th sample, sym_valid pulses one cycle with Ichannel=1, Qchannel=0 (soft_i=160000, soft_q=-80000 with QPSK_DEMOD_SOFT_EN).
- All four symbols: sample_in=±300 paired with ref signs chosen to give (I,Q) = 00, 01, 11, 10 in consecutive symbols -> four sym_valid pulses exactly 16 valid samples apart, with matching bits.
- Gaps: the same stimulus with sample_valid low every other cycle -> identical decisions; sym_valid arrives 1 cycle after the 16th valid sample.
- Resync: sym_sync at cnt=7 -> no sym_valid for the partial symbol; the next decision comes 16 valid samples after the sync. With sym_sync at cnt=15 -> no decision that cycle.
- Tie and extremes: sample_in=-512, ref_i=-512 for 16 samples -> full_i=4194304, no overflow, Ichannel=1. With ref_q=0 -> full_q=0 and Qchannel=1.
